// File: rtl/servo_pwm_scheduler.sv
// servo_pwm_scheduler: frame-synchronous servo PWM generator.
// A prescaler makes a 1 us tick, and a frame counter counts those ticks.
// Accepted commands are clamped to the legal servo range and parked in a
// one-deep holding register. At each frame boundary the applied pulse width
// slews toward the target by at most STEP_US.
module servo_pwm_scheduler #(
   parameter int CLKS_PER_US = 50,
   parameter int FRAME_US    = 20000,
   parameter int MIN_US      = 500,
   parameter int CENTRE_US   = 1500,
   parameter int MAX_US      = 2500,
   parameter int STEP_US     = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        cmd_valid,
   input  logic [11:0] cmd_pulse_us,
   output logic        cmd_ready,
   output logic        pwm_out,
   output logic        frame_start,
   output logic [11:0] current_us,
   output logic [11:0] target_us,
   output logic        at_target,
   output logic        cmd_clamped
);

   localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam int CW = (UW > 12) ? UW : 12;

   localparam logic [PW-1:0] PSC_LAST = PW'(CLKS_PER_US - 1);
   localparam logic [UW-1:0] US_LAST  = UW'(FRAME_US - 1);
   localparam logic [11:0]   MIN_V    = 12'(MIN_US);
   localparam logic [11:0]   MAX_V    = 12'(MAX_US);
   localparam logic [11:0]   CENTRE_V = 12'(CENTRE_US);
   localparam logic [11:0]   STEP_V   = 12'(STEP_US);

   logic [PW-1:0] psc;
   logic [UW-1:0] us_cnt;
   logic          pending;
   logic [11:0]   hold;

   logic          psc_wrap;
   logic          boundary;
   logic          accept;
   logic          raw_low;
   logic          raw_high;
   logic [11:0]   clamp_val;
   logic [11:0]   next_target;
   logic [11:0]   diff;
   logic [11:0]   step;
   logic [11:0]   next_current;

   assign psc_wrap    = (psc == PSC_LAST);
   assign boundary    = enable & psc_wrap & (us_cnt == US_LAST);
   assign cmd_ready   = ~pending;
   assign accept      = cmd_valid & cmd_ready;
   assign at_target   = (current_us == target_us);
   // The first clock of a frame is any enabled clock with both counters at 0,
   // which also covers the first clock after re-enable.
   assign frame_start = reset & enable & (psc == '0) & (us_cnt == '0);

   // Clamp the raw command and build the boundary update (compare first, then subtract).
   always_comb begin
      raw_low      = (cmd_pulse_us < MIN_V);
      raw_high     = (cmd_pulse_us > MAX_V);
      clamp_val    = cmd_pulse_us;
      next_target  = target_us;
      diff         = '0;
      step         = '0;
      next_current = current_us;
      if (raw_low)
         clamp_val = MIN_V;
      else if (raw_high)
         clamp_val = MAX_V;
      // A command accepted on the boundary clock bypasses the holding register.
      if (accept)
         next_target = clamp_val;
      else if (pending)
         next_target = hold;
      if (next_target > current_us) begin
         diff         = next_target - current_us;
         step         = (diff > STEP_V) ? STEP_V : diff;
         next_current = current_us + step;
      end else begin
         diff         = current_us - next_target;
         step         = (diff > STEP_V) ? STEP_V : diff;
         next_current = current_us - step;
      end
   end

   // Prescaler and microsecond frame counter; held at zero while disabled.
   always_ff @(posedge clock) begin
      if (!reset) begin
         psc    <= '0;
         us_cnt <= '0;
      end else if (!enable) begin
         psc    <= '0;
         us_cnt <= '0;
      end else if (psc_wrap) begin
         psc    <= '0;
         us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + UW'(1);
      end else begin
         psc    <= psc + PW'(1);
      end
   end

   // Command holding register, target latch and per-frame slew.
   always_ff @(posedge clock) begin
      if (!reset) begin
         current_us  <= CENTRE_V;
         target_us   <= CENTRE_V;
         pending     <= 1'b0;
         hold        <= CENTRE_V;
         cmd_clamped <= 1'b0;
      end else begin
         cmd_clamped <= accept & (raw_low | raw_high);
         if (boundary) begin
            current_us <= next_current;
            target_us  <= next_target;
            pending    <= 1'b0;
         end else if (accept) begin
            hold    <= clamp_val;
            pending <= 1'b1;
         end
      end
   end

   // Registered PWM pin: high while the frame position is inside the pulse.
   always_ff @(posedge clock) begin
      if (!reset)
         pwm_out <= 1'b0;
      else
         pwm_out <= enable & (CW'(us_cnt) < CW'(current_us));
   end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Self-checking bench for servo_pwm_scheduler with a shortened frame.
// A reference model tracks the position in the frame as one linear clock
// count and applies the command/slew rules directly; every clock the DUT
// outputs are compared with it, alongside table vectors and hand sequences.
module tb_servo_pwm_scheduler;

   localparam int CLKS   = 3;
   localparam int FRAME  = 400;
   localparam int MIN    = 100;
   localparam int CENTRE = 200;
   localparam int MAX    = 350;
   localparam int STEP   = 20;
   localparam int FP     = FRAME * CLKS;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        cmd_valid;
   logic [11:0] cmd_pulse_us;
   logic        cmd_ready;
   logic        pwm_out;
   logic        frame_start;
   logic [11:0] current_us;
   logic [11:0] target_us;
   logic        at_target;
   logic        cmd_clamped;

   servo_pwm_scheduler #(
      .CLKS_PER_US(CLKS), .FRAME_US(FRAME), .MIN_US(MIN),
      .CENTRE_US(CENTRE), .MAX_US(MAX), .STEP_US(STEP)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_pulse_us(cmd_pulse_us),
      .cmd_ready(cmd_ready), .pwm_out(pwm_out), .frame_start(frame_start),
      .current_us(current_us), .target_us(target_us),
      .at_target(at_target), .cmd_clamped(cmd_clamped)
   );

   always #5 clock = ~clock;

   // reference model state
   int m_t, m_cur, m_tgt, m_hold;
   bit m_pend, m_pwm, m_clamp, m_ok, last_bnd;
   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [11:0] raw;
      int          tgt;
      bit          clamped;
   } vec_t;
   vec_t vecs[8];

   function automatic int clampv(int v);
      if (v < MIN) return MIN;
      if (v > MAX) return MAX;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
         if (n_total - n_pass >= 30) begin
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
         end
      end
   endtask

   task automatic check_cycle();
      logic [28:0] a, e;
      a = {pwm_out, frame_start, cmd_ready, at_target, cmd_clamped, current_us, target_us};
      e = {m_pwm, (reset && enable && m_t == 0), !m_pend, (m_cur == m_tgt), m_clamp,
           12'(m_cur), 12'(m_tgt)};
      check("per_cycle{pwm,fs,rdy,at,clmp,cur,tgt}", 32'(a), 32'(e));
   endtask

   // Advance one clock: update the model from the inputs, then compare.
   task automatic tick();
      int nt, d;
      bit acc;
      last_bnd = 0;
      if (!reset) begin
         m_t = 0; m_cur = CENTRE; m_tgt = CENTRE; m_hold = 0;
         m_pend = 0; m_pwm = 0; m_clamp = 0; m_ok = 1;
      end else if (m_ok) begin
         acc     = cmd_valid && !m_pend;
         m_clamp = acc && (cmd_pulse_us < MIN || cmd_pulse_us > MAX);
         m_pwm   = enable && (m_t / CLKS < m_cur);
         if (enable && m_t == FP - 1) begin
            last_bnd = 1;
            nt = acc ? clampv(int'(cmd_pulse_us)) : (m_pend ? m_hold : m_tgt);
            d  = nt - m_cur;
            if (d > STEP) d = STEP;
            else if (d < -STEP) d = -STEP;
            m_cur  = m_cur + d;
            m_tgt  = nt;
            m_pend = 0;
         end else if (acc) begin
            m_hold = clampv(int'(cmd_pulse_us));
            m_pend = 1;
         end
         m_t = enable ? (m_t + 1) % FP : 0;
      end
      @(posedge clock);
      #1;
      if (m_ok) check_cycle();
   endtask

   task automatic wait_boundary();
      for (int i = 0; i < FP + 5; i++) begin
         tick();
         if (last_bnd) return;
      end
      check("wait_boundary_timeout", 0, 1);
   endtask

   task automatic wait_pwm_high();
      for (int i = 0; i < 2 * FP; i++) begin
         if (m_pwm) return;
         tick();
      end
      check("wait_pwm_timeout", 0, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pwm"}, pwm_out, 0);
      check({tag, "_fs"}, frame_start, 0);
      check({tag, "_rdy"}, cmd_ready, 1);
      check({tag, "_cur"}, current_us, CENTRE);
      check({tag, "_tgt"}, target_us, CENTRE);
      check({tag, "_at"}, at_target, 1);
      check({tag, "_clmp"}, cmd_clamped, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, first_fs, pre, exp_hi;
      bit got, rb;

      vecs[0] = '{12'd3000, MAX, 1'b1};
      vecs[1] = '{12'd50,   MIN, 1'b1};
      vecs[2] = '{12'd100,  100, 1'b0};
      vecs[3] = '{12'd350,  350, 1'b0};
      vecs[4] = '{12'd99,   MIN, 1'b1};
      vecs[5] = '{12'd351,  MAX, 1'b1};
      vecs[6] = '{12'd0,    MIN, 1'b1};
      vecs[7] = '{12'd4095, MAX, 1'b1};

      m_ok = 0;
      reset = 0; enable = 0; cmd_valid = 0; cmd_pulse_us = '0;
      tick(); tick();
      check_reset_values("reset");

      // idle frame: pulse width and frame period
      reset = 1; enable = 1;
      #1;
      check("fs_after_reset", frame_start, 1);
      hi = 0; first_fs = 0;
      for (int k = 1; k <= FP; k++) begin
         tick();
         hi += int'(pwm_out);
         if (frame_start && first_fs == 0) first_fs = k;
      end
      check("idle_high_clocks", hi, CENTRE * CLKS);
      check("idle_frame_period", first_fs, FP);
      check("idle_cur", current_us, CENTRE);

      // mid-frame command: slew 220..300 over five frames
      for (int k = 0; k < 100; k++) tick();
      cmd_valid = 1; cmd_pulse_us = 12'd300;
      tick();
      cmd_valid = 0;
      check("slew_rdy_low", cmd_ready, 0);
      wait_boundary();
      check("slew_rdy_back", cmd_ready, 1);
      check("slew_f1", current_us, 220);
      check("slew_tgt", target_us, 300);
      wait_boundary(); check("slew_f2", current_us, 240);
      wait_boundary(); check("slew_f3", current_us, 260);
      wait_boundary(); check("slew_f4", current_us, 280);
      check("slew_at_f4", at_target, 0);
      wait_boundary(); check("slew_f5", current_us, 300);
      check("slew_at_f5", at_target, 1);

      // clamp table
      foreach (vecs[i]) begin
         cmd_valid = 1; cmd_pulse_us = vecs[i].raw;
         tick();
         cmd_valid = 0;
         check($sformatf("clamp%0d_pulse", i), cmd_clamped, vecs[i].clamped);
         tick();
         check($sformatf("clamp%0d_pulse_end", i), cmd_clamped, 0);
         wait_boundary();
         check($sformatf("clamp%0d_tgt", i), target_us, vecs[i].tgt);
         check($sformatf("clamp%0d_range", i),
               (current_us >= MIN && current_us <= MAX), 1);
      end

      // back-to-back commands: second stalls until the boundary
      cmd_valid = 1; cmd_pulse_us = 12'd150;
      tick();
      cmd_pulse_us = 12'd330;
      got = 0;
      for (int k = 0; k < FP + 5; k++) begin
         rb = cmd_ready;
         tick();
         if (rb) begin got = 1; break; end
      end
      cmd_valid = 0;
      check("b2b_second_accepted", got, 1);
      check("b2b_first_applied", target_us, 150);
      wait_boundary();
      check("b2b_second_applied", target_us, 330);

      // command on the boundary clock bypasses the holding register
      for (int k = 0; k < FP + 5 && m_t != FP - 1; k++) tick();
      pre = m_cur;
      cmd_valid = 1; cmd_pulse_us = 12'd100;
      tick();
      cmd_valid = 0;
      check("bnd_tgt", target_us, 100);
      check("bnd_rdy", cmd_ready, 1);
      check("bnd_cur", current_us, (pre - 100 > STEP) ? pre - STEP : 100);

      // enable dropped mid-pulse, command accepted while disabled, re-enable
      wait_pwm_high();
      for (int k = 0; k < 5; k++) tick();
      enable = 0;
      tick();
      check("dis_pwm", pwm_out, 0);
      check("dis_fs", frame_start, 0);
      cmd_valid = 1; cmd_pulse_us = 12'd250;
      tick();
      cmd_valid = 0;
      check("dis_cmd_accepted", cmd_ready, 0);
      for (int k = 0; k < 20; k++) tick();
      enable = 1;
      #1;
      check("reen_fs", frame_start, 1);
      exp_hi = m_cur * CLKS;
      hi = 0;
      for (int k = 1; k <= FP; k++) begin
         tick();
         hi += int'(pwm_out);
      end
      check("reen_full_pulse", hi, exp_hi);

      // reset mid-pulse
      wait_pwm_high();
      tick();
      reset = 0;
      tick();
      check_reset_values("midrst");
      reset = 1;

      // randomized traffic against the model
      for (int k = 0; k < 12000; k++) begin
         cmd_valid    = ($urandom % 6 == 0);
         cmd_pulse_us = 12'($urandom_range(0, 600));
         if ($urandom % 700 == 0) enable = ~enable;
         reset = ($urandom % 5000 != 0);
         tick();
      end
      reset = 1;
      enable = 1;
      cmd_valid = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/servo_pwm_scheduler.md
# servo_pwm_scheduler

Frame-synchronous servo controller. It accepts target pulse-width commands through a valid/ready handshake, clamps each command to the legal servo range, and slews the active pulse width toward the target by a bounded step once per 20 ms PWM frame. It produces the servo PWM pin itself from an internal microsecond prescaler and frame counter. It sits between the command source (switch/UART decode logic) and the servo output pin, and replaces free-running divider/comparator sequencing.

## Interface
- CLKS_PER_US, default 50: input clocks per microsecond (50 MHz clock); must be ≥1.
- FRAME_US, default 20000: PWM frame length in µs.
- MIN_US, default 500: pulse width for the −90° position, in µs.
- CENTRE_US, default 1500: pulse width for the 0° position; also the reset position.
- MAX_US, default 2500: pulse width for the +90° position, in µs.
- STEP_US, default 20: maximum change of the active pulse width per frame, in µs; must be ≥1.
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-low reset.
- enable, input, 1: 1 runs the frame timing and PWM; 0 freezes timing and forces the pin low.
- cmd_valid, input, 1: command present on cmd_pulse_us.
- cmd_pulse_us, input, 12: requested pulse width in µs, unsigned.
- cmd_ready, output, 1: holding register empty; a command is accepted on cmd_valid & cmd_ready.
- pwm_out, output, 1: servo signal pin, registered.
- frame_start, output, 1: one-cycle pulse on the first clock of each frame.
- current_us, output, 12: pulse width applied in the current frame.
- target_us, output, 12: latched, clamped target.
- at_target, output, 1: current_us == target_us.
- cmd_clamped, output, 1: one-cycle pulse when an accepted command was out of range.

## Operation
- Timing chain: prescaler counts 0..CLKS_PER_US−1. At wrap it advances us_cnt, which counts 0..FRAME_US−1.
- Frame boundary: the clock where prescaler == CLKS_PER_US−1 and us_cnt == FRAME_US−1. Both counters wrap to 0 on that clock.
- PWM: pwm_out is registered as enable & (us_cnt < current_us). Each frame therefore carries exactly current_us × CLKS_PER_US high clocks.
- Command accept: on cmd_valid & cmd_ready, clamp the value to [MIN_US, MAX_US], store it in the holding register, set pending, and drop cmd_ready. cmd_clamped pulses on the next cycle if the raw value was < MIN_US or > MAX_US.
- Second command while pending: it is stalled (cmd_ready=0) and is never dropped or overwritten.
- Boundary update, computed in this order:
  - next_target = pending ? hold : target_us.
  - current_us moves toward next_target by min(STEP_US, |next_target − current_us|).
  - pending clears and cmd_ready returns to 1.
- Accept on the boundary clock: the command bypasses the holding register and is used as next_target in the same update.
- Disabled (enable=0):
  - Counters are held at 0, pwm_out=0, frame_start=0, and no boundary updates occur.
  - Commands are still accepted into the holding register.
- Re-enable: counting restarts from prescaler=0, us_cnt=0, and frame_start pulses on the first enabled clock.
- Arithmetic: all µs quantities are 12-bit unsigned. Compare before subtracting, so the step never underflows and never overshoots the target.

## Timing
- Reset (reset=0 at a clock edge), all applied on that edge:
  - pwm_out=0, frame_start=0, cmd_clamped=0, cmd_ready=1.
  - current_us=CENTRE_US, target_us=CENTRE_US, at_target=1.
  - Counters=0, pending=0.
- Reset mid-frame or mid-pulse: aborts immediately; the pin goes low on the same edge.
- Accept-to-target latency: applied at the next frame boundary (≤ FRAME_US×CLKS_PER_US clocks).
- pwm_out lags us_cnt by one clock. The pulse's rising edge is the clock after frame_start.
- New current_us takes effect in the frame that starts on the clock after the boundary.
- Full 500→2500 sweep takes ceil(2000/STEP_US) frames (100 frames by default).

## Test plan
- Reset release, no commands: pwm_out high for 75000 clocks of every 1,000,000; frame_start period is 1,000,000; current_us=1500; at_target=1.
- Command 1600 mid-frame: cmd_ready low until the boundary, then high. current_us = 1520, 1540, …, 1600 over 5 frames; at_target rises after frame 5.
- Command 3000, then a separate command of 100: each yields a cmd_clamped pulse. target_us becomes 2500, then 500; current_us never leaves [500, 2500].
- Two back-to-back cmd_valid cycles: second command stalls until the boundary, then is accepted. No command is lost.
- Command issued on the boundary clock: used in the same update, so current_us changes by STEP_US in the very next frame.
- enable dropped mid-pulse: pwm_out=0 the next clock. Re-enable: frame_start on the first enabled clock and a full-width pulse. Reset asserted mid-pulse: all outputs at reset values on that edge.
